// File: rtl/dff_pipe.sv
// Elastic W-bit register pipeline of D stages with valid/ready flow control.
// Optional DFF_PIPE_CLEAR_DATA_EN: data registers are reset/flushed to zero.
module dff_pipe #(
    parameter int W = 32,
    parameter int D = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [W-1:0]           in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [W-1:0]           out_data,
    input  logic                   out_ready,
    output logic [$clog2(D+1)-1:0] count
);

    localparam int CW = $clog2(D+1);

    logic [D-1:0] v;
    logic [W-1:0] q [D];

    logic [D-1:0] r;
    logic [D-1:0] up_v;
    logic [W-1:0] up_q [D];
    logic [D-1:0] load;
    logic         go;
    logic         in_xfer;
    logic         out_xfer;

    assign go = en & ~flush;

    // A stage can take a word if any stage from it to the output is empty
    // or the output is being drained; this flattens the ready chain.
    always_comb begin
        for (int i = 0; i < D; i++) begin
            logic rr;
            rr = out_ready;
            for (int j = i; j < D; j++) begin
                rr = rr | ~v[j];
            end
            r[i] = rr;
        end
    end

    always_comb begin
        up_v[0] = in_valid;
        up_q[0] = in_data;
        for (int i = 1; i < D; i++) begin
            up_v[i] = v[i-1];
            up_q[i] = q[i-1];
        end
    end

    assign load     = {D{go}} & r;
    assign in_ready = go & r[0];
    assign out_valid = go & v[D-1];
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
        end else if (flush) begin
            v <= '0;
        end else begin
            for (int i = 0; i < D; i++) begin
                if (load[i]) begin
                    v[i] <= up_v[i];
                end
            end
        end
    end

`ifdef DFF_PIPE_CLEAR_DATA_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) begin
                q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < D; i++) begin
                q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < D; i++) begin
                if (load[i] & up_v[i]) begin
                    q[i] <= up_q[i];
                end
            end
        end
    end

    assign out_data = out_valid ? q[D-1] : '0;
`else
    always_ff @(posedge clk) begin
        for (int i = 0; i < D; i++) begin
            if (load[i] & up_v[i]) begin
                q[i] <= up_q[i];
            end
        end
    end

    assign out_data = q[D-1];
`endif

    // Full with a simultaneous push and pop may wrap mid-expression; the
    // modular result is still the correct occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + CW'(in_xfer) - CW'(out_xfer);
        end
    end

`ifndef SYNTHESIS
    a_count_matches_valid : assert property (
        @(posedge clk) disable iff (!rst_n)
        int'(count) == $countones(v)
    );

    a_stall_holds_output : assert property (
        @(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (v[D-1] && $stable(q[D-1]))
    );
`endif

endmodule
